dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single synchronous-read data memory between two requesters: port A (core MEM stage) and port B (secondary master, e.g. program loader or debug).
- Per accepted request it:
  - generates the word address, byte write-enables and lane-replicated store data;
  - tracks the one-cycle read latency;
  - returns the raw read word to the owner, with the captured byte offset and load type for the WB-stage load extension unit.
- Arbitration is fixed priority to A, with a starvation guard for B.

Parameters:
- DMEM_AW, 14, word-address width driven to DMEM.
- STARVE_LIMIT, 8, consecutive stalled-B cycles before B is forced a grant; 0 disables the guard.
- CNT_W, 4, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- a_req_valid  in  1  port A request.
- a_req_ready  out  1  port A granted this cycle.
- a_req_we  in  1  1 = store, 0 = load.
- a_req_addr  in  32  byte address.
- a_req_wdata  in  32  store data, right-aligned.
- a_req_type  in  3  access type, `DMEM_LB/LH/LW/LBU/LHU codes from defines.vh.
- a_rsp_valid  out  1  response for port A.
- a_rsp_rdata  out  32  raw DMEM word.
- a_rsp_offset  out  2  captured addr[1:0].
- a_rsp_type  out  3  captured req_type.
- a_rsp_err  out  1  misaligned access (optional feature).
- b_*  same set and widths as a_* for port B.
- dmem_en  out  1  DMEM enable.
- dmem_we  out  4  byte write enables.
- dmem_addr  out  DMEM_AW  word address = addr[DMEM_AW+1:2].
- dmem_din  out  32  lane-replicated store data.
- dmem_dout  in  32  read data, valid one cycle after dmem_en.

Behaviour:
- Arbitration is combinational each cycle:
  - grant_b = b_req_valid & (~a_req_valid | force_b);
  - grant_a = a_req_valid & ~grant_b;
  - x_req_ready = grant_x.
  - Handshake fires on valid & ready.
  - Requesters hold valid and payload stable until ready.
- Starvation counter b_wait (CNT_W bits):
  - increments when b_req_valid & ~grant_b;
  - clears when grant_b or ~b_req_valid;
  - saturates at STARVE_LIMIT;
  - force_b = (STARVE_LIMIT != 0) & (b_wait == STARVE_LIMIT).
- DMEM drive in the accept cycle: dmem_en = grant_a | grant_b, with the address and data muxed from the granted port.
- Byte write enables:
  - dmem_we = 0 for loads.
  - Stores by access size:
    - byte (LB/LBU): dmem_we = 4'b0001 << off, dmem_din = {4{wdata[7:0]}};
    - half (LH/LHU): dmem_we = 4'b0011 << off, dmem_din = {2{wdata[15:0]}};
    - word (LW): dmem_we = 4'b1111, dmem_din = wdata.
  - An unknown type code gives dmem_we = 0 and a response with rdata undefined and err = 0.
- Response pipeline:
  - One register stage captures owner (A/B), offset, type, err and valid.
  - Exactly 1 cycle after accept, the owner's rsp_valid = 1 for one cycle. This applies to loads and stores; a store response is a write ack.
  - rsp_rdata = dmem_dout for loads, 0 for stores.
  - The non-owner's rsp_valid = 0.
- Back-to-back: a new accept is allowed every cycle, so throughput is 1 request per cycle. The A-then-B response order matches grant order.
- Reset (rst_n = 0 at a rising clk):
  - all rsp_valid = 0, rsp_err = 0, rsp_offset = 0, rsp_type = 0, rsp_rdata = 0, b_wait = 0;
  - ready and dmem_en are forced 0 while rst_n = 0;
  - an in-flight response is dropped, and no rsp_valid is seen after reset.
- Both ports valid with b_wait < limit: A granted, B stalls, b_wait increments.
- Both ports valid with b_wait == limit: B granted, b_wait clears, A stalls for one cycle.

Optional Feature:
- DMEM_ARB_ERR_EN defined:
  - misalignment check: half at offset 1 or 3, or word at offset != 0;
  - a misaligned request is still accepted (ready = 1), but dmem_en = 0 and dmem_we = 0;
  - next cycle rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
- DMEM_ARB_ERR_EN undefined:
  - no check; rsp_err tied 0;
  - the access proceeds with enables computed by the shift, truncated to 4 bits.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with both ports valid -> ready = 0, dmem_en = 0, and all rsp_valid = 0 on the cycle after release.
- A load of LW at 0x0000_0010 with dmem_dout = 0xDEADBEEF -> dmem_addr = 4, dmem_we = 0; one cycle later a_rsp_valid = 1, rdata = 0xDEADBEEF, offset = 0, type = `DMEM_LW.
- B stores SB at 0x0000_0023 with wdata 0x0000_00A5 -> dmem_we = 4'b1000, dmem_din = 0xA5A5A5A5; b_rsp_valid = 1 next cycle with rdata = 0.
- A and B both continuously valid, STARVE_LIMIT = 8 -> A granted for 8 cycles, B granted on cycle 9, b_wait = 0 after; pattern repeats, and responses route to the correct owner.
- Reset asserted the cycle after an accepted A load -> a_rsp_valid stays 0; no response is emitted after release.
- With DMEM_ARB_ERR_EN, A does LH at 0x0000_0003 -> dmem_en = 0; next cycle a_rsp_valid = 1, a_rsp_err = 1, rdata = 0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one data-memory requester port of dmem_arbiter.
// The requester uses the master modport; the arbiter uses the slave modport.
interface dmem_arbiter_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_type;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_offset;
    logic [2:0]  rsp_type;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_type,
        input  req_ready, rsp_valid, rsp_rdata, rsp_offset, rsp_type, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_type,
        output req_ready, rsp_valid, rsp_rdata, rsp_offset, rsp_type, rsp_err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a synchronous-read data memory (A has priority, B starvation guard).
// Define DMEM_ARB_ERR_EN to reject misaligned half/word accesses with an error response.
module dmem_arbiter #(
    parameter int DMEM_AW      = 14,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_arbiter_if.slave      a,
    dmem_arbiter_if.slave      b,
    output logic               dmem_en,
    output logic [3:0]         dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_din,
    input  logic [31:0]        dmem_dout
);

    localparam logic [2:0] DMEM_LB  = 3'b000;
    localparam logic [2:0] DMEM_LH  = 3'b001;
    localparam logic [2:0] DMEM_LW  = 3'b010;
    localparam logic [2:0] DMEM_LBU = 3'b100;
    localparam logic [2:0] DMEM_LHU = 3'b101;

    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]   b_wait, b_wait_d;
    logic               force_b, grant_a, grant_b, accept;
    logic               sel_we;
    logic [DMEM_AW+1:0] sel_addr;
    logic [31:0]        sel_wdata;
    logic [2:0]         sel_type;
    logic [3:0]         lane_be;
    logic [31:0]        lane_din;
    logic               misalign;

    logic               rsp_valid_q, owner_b_q, load_q, err_q;
    logic [1:0]         offset_q;
    logic [2:0]         type_q;
    logic [31:0]        rsp_rdata;
    logic               own_a, own_b;

    // Grants are gated by rst_n so nothing is accepted while reset is held.
    assign force_b = (STARVE_LIMIT != 0) && (b_wait == WAIT_MAX);
    assign grant_b = rst_n & b.req_valid & (~a.req_valid | force_b);
    assign grant_a = rst_n & a.req_valid & ~grant_b;
    assign accept  = grant_a | grant_b;

    assign a.req_ready = grant_a;
    assign b.req_ready = grant_b;

    always_comb begin
        b_wait_d = b_wait;
        if (!b.req_valid || grant_b)
            b_wait_d = '0;
        else if (b_wait != WAIT_MAX)
            b_wait_d = b_wait + 1'b1;
    end

    assign sel_we    = grant_b ? b.req_we : a.req_we;
    assign sel_addr  = grant_b ? b.req_addr[DMEM_AW+1:0] : a.req_addr[DMEM_AW+1:0];
    assign sel_wdata = grant_b ? b.req_wdata : a.req_wdata;
    assign sel_type  = grant_b ? b.req_type : a.req_type;

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        lane_be  = 4'b0000;
        lane_din = sel_wdata;
        misalign = 1'b0;
        case (sel_type)
            DMEM_LB, DMEM_LBU: begin
                lane_be  = 4'b0001 << sel_addr[1:0];
                lane_din = {4{sel_wdata[7:0]}};
            end
            DMEM_LH, DMEM_LHU: begin
                lane_be  = 4'b0011 << sel_addr[1:0];
                lane_din = {2{sel_wdata[15:0]}};
`ifdef DMEM_ARB_ERR_EN
                misalign = sel_addr[0];
`endif
            end
            DMEM_LW: begin
                lane_be  = 4'b1111;
`ifdef DMEM_ARB_ERR_EN
                misalign = (sel_addr[1:0] != 2'b00);
`endif
            end
            default: lane_be = 4'b0000;
        endcase
    end

    // A misaligned request is still handshaken but never reaches the memory.
    assign dmem_en   = accept & ~misalign;
    assign dmem_we   = (dmem_en && sel_we) ? lane_be : 4'b0000;
    assign dmem_addr = sel_addr[DMEM_AW+1:2];
    assign dmem_din  = lane_din;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_wait      <= '0;
            rsp_valid_q <= 1'b0;
            owner_b_q   <= 1'b0;
            load_q      <= 1'b0;
            err_q       <= 1'b0;
            offset_q    <= 2'b00;
            type_q      <= 3'b000;
        end else begin
            b_wait      <= b_wait_d;
            rsp_valid_q <= accept;
            if (accept) begin
                owner_b_q <= grant_b;
                load_q    <= ~sel_we;
                err_q     <= misalign;
                offset_q  <= sel_addr[1:0];
                type_q    <= sel_type;
            end
        end
    end

    // Response valid is also masked by rst_n so an in-flight response is dropped immediately.
    assign own_a     = rst_n & rsp_valid_q & ~owner_b_q;
    assign own_b     = rst_n & rsp_valid_q &  owner_b_q;
    assign rsp_rdata = (load_q && !err_q) ? dmem_dout : 32'h0;

    assign a.rsp_valid  = own_a;
    assign a.rsp_rdata  = own_a ? rsp_rdata : 32'h0;
    assign a.rsp_offset = own_a ? offset_q : 2'b00;
    assign a.rsp_type   = own_a ? type_q : 3'b000;
    assign a.rsp_err    = own_a & err_q;

    assign b.rsp_valid  = own_b;
    assign b.rsp_rdata  = own_b ? rsp_rdata : 32'h0;
    assign b.rsp_offset = own_b ? offset_q : 2'b00;
    assign b.rsp_type   = own_b ? type_q : 3'b000;
    assign b.rsp_err    = own_b & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter plus hand-written starvation and reset sequences.
module tb_dmem_arbiter;

    localparam logic [2:0] T_LB  = 3'b000;
    localparam logic [2:0] T_LH  = 3'b001;
    localparam logic [2:0] T_LW  = 3'b010;
    localparam logic [2:0] T_LBU = 3'b100;
    localparam logic [2:0] T_LHU = 3'b101;
    localparam logic [2:0] T_BAD = 3'b011;

    typedef struct {
        logic        port;      // 0 = A, 1 = B
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  typ;
        logic [31:0] dout;
        logic        exp_en;
        logic [3:0]  exp_we;
        logic [13:0] exp_addr;
        logic [31:0] exp_din;
        logic        chk_rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmem_en;
    logic [3:0]  dmem_we;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_din;
    logic [31:0] dmem_dout;

    int total = 0;
    int bad   = 0;

    dmem_arbiter_if a_if ();
    dmem_arbiter_if b_if ();

    dmem_arbiter #(.DMEM_AW(14), .STARVE_LIMIT(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a_if),
        .b         (b_if),
        .dmem_en   (dmem_en),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_din  (dmem_din),
        .dmem_dout (dmem_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic port, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] typ,
                                input logic [31:0] dout, input logic exp_en,
                                input logic [3:0] exp_we, input logic [13:0] exp_addr,
                                input logic [31:0] exp_din, input logic chk_rd,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.port = port; v.we = we; v.addr = addr; v.wdata = wdata; v.typ = typ; v.dout = dout;
        v.exp_en = exp_en; v.exp_we = exp_we; v.exp_addr = exp_addr; v.exp_din = exp_din;
        v.chk_rd = chk_rd; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic idle_ports();
        a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_addr = 32'h0;
        a_if.req_wdata = 32'h0; a_if.req_type = T_LW;
        b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_addr = 32'h0;
        b_if.req_wdata = 32'h0; b_if.req_type = T_LW;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic        rv_a, rv_b, rv;
        logic [1:0]  roff;
        logic [2:0]  rtyp;
        logic        rerr;
        logic [31:0] rrd;
        @(negedge clk);
        if (v.port == 1'b0) begin
            a_if.req_valid = 1'b1; a_if.req_we = v.we; a_if.req_addr = v.addr;
            a_if.req_wdata = v.wdata; a_if.req_type = v.typ;
        end else begin
            b_if.req_valid = 1'b1; b_if.req_we = v.we; b_if.req_addr = v.addr;
            b_if.req_wdata = v.wdata; b_if.req_type = v.typ;
        end
        #1;
        check($sformatf("v%0d_ready_a", idx), 32'(a_if.req_ready), 32'(v.port == 1'b0));
        check($sformatf("v%0d_ready_b", idx), 32'(b_if.req_ready), 32'(v.port == 1'b1));
        check($sformatf("v%0d_en", idx), 32'(dmem_en), 32'(v.exp_en));
        check($sformatf("v%0d_we", idx), 32'(dmem_we), 32'(v.exp_we));
        check($sformatf("v%0d_addr", idx), 32'(dmem_addr), 32'(v.exp_addr));
        check($sformatf("v%0d_din", idx), dmem_din, v.exp_din);
        @(posedge clk);
        #1;
        idle_ports();
        dmem_dout = v.dout;
        #1;
        rv_a = a_if.rsp_valid;
        rv_b = b_if.rsp_valid;
        rv   = v.port ? rv_b : rv_a;
        roff = v.port ? b_if.rsp_offset : a_if.rsp_offset;
        rtyp = v.port ? b_if.rsp_type : a_if.rsp_type;
        rerr = v.port ? b_if.rsp_err : a_if.rsp_err;
        rrd  = v.port ? b_if.rsp_rdata : a_if.rsp_rdata;
        check($sformatf("v%0d_rsp_valid", idx), 32'(rv), 32'd1);
        check($sformatf("v%0d_other_valid", idx), 32'(v.port ? rv_a : rv_b), 32'd0);
        check($sformatf("v%0d_offset", idx), 32'(roff), 32'(v.addr[1:0]));
        check($sformatf("v%0d_type", idx), 32'(rtyp), 32'(v.typ));
        check($sformatf("v%0d_err", idx), 32'(rerr), 32'(v.exp_err));
        if (v.chk_rd)
            check($sformatf("v%0d_rdata", idx), rrd, v.exp_rdata);
    endtask

    vec_t vecs[$];

    initial begin
        logic prev_a, prev_b, exp_b;

        rst_n     = 1'b0;
        dmem_dout = 32'h0;
        idle_ports();

        // port, we, addr, wdata, type, dout | en, we, addr, din, chk_rd, rdata, err
        vecs.push_back(mk(0, 0, 32'h0000_0010, 32'h0, T_LW, 32'hDEAD_BEEF,
                          1, 4'b0000, 14'h0004, 32'h0, 1, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk(1, 1, 32'h0000_0023, 32'h0000_00A5, T_LB, 32'h1357_9BDF,
                          1, 4'b1000, 14'h0008, 32'hA5A5_A5A5, 1, 32'h0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_0102, 32'h1234_BEEF, T_LH, 32'hFFFF_FFFF,
                          1, 4'b1100, 14'h0040, 32'hBEEF_BEEF, 1, 32'h0, 0));
        vecs.push_back(mk(1, 0, 32'h0001_0005, 32'h0, T_LBU, 32'h1122_3344,
                          1, 4'b0000, 14'h0001, 32'h0, 1, 32'h1122_3344, 0));
        vecs.push_back(mk(0, 1, 32'h0000_FFFC, 32'hCAFE_F00D, T_LW, 32'h0,
                          1, 4'b1111, 14'h3FFF, 32'hCAFE_F00D, 1, 32'h0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_0000, 32'hFFFF_FF5A, T_LB, 32'h0,
                          1, 4'b0001, 14'h0000, 32'h5A5A_5A5A, 1, 32'h0, 0));
        vecs.push_back(mk(1, 1, 32'h0000_0008, 32'hAAAA_7788, T_LH, 32'h0,
                          1, 4'b0011, 14'h0002, 32'h7788_7788, 1, 32'h0, 0));
        vecs.push_back(mk(0, 0, 32'h0000_0006, 32'h0, T_LHU, 32'h8000_7FFF,
                          1, 4'b0000, 14'h0001, 32'h0, 1, 32'h8000_7FFF, 0));
        vecs.push_back(mk(0, 1, 32'h0000_0004, 32'h1234_5678, T_BAD, 32'h0,
                          1, 4'b0000, 14'h0001, 32'h1234_5678, 0, 32'h0, 0));
`ifdef DMEM_ARB_ERR_EN
        vecs.push_back(mk(0, 0, 32'h0000_0003, 32'h0, T_LH, 32'h55AA_55AA,
                          0, 4'b0000, 14'h0000, 32'h0, 1, 32'h0, 1));
        vecs.push_back(mk(1, 1, 32'h0000_0007, 32'h0000_BEEF, T_LH, 32'h0,
                          0, 4'b0000, 14'h0001, 32'hBEEF_BEEF, 1, 32'h0, 1));
        vecs.push_back(mk(0, 1, 32'h0000_0001, 32'h0102_0304, T_LW, 32'h0,
                          0, 4'b0000, 14'h0000, 32'h0102_0304, 1, 32'h0, 1));
`else
        vecs.push_back(mk(0, 0, 32'h0000_0003, 32'h0, T_LH, 32'h55AA_55AA,
                          1, 4'b0000, 14'h0000, 32'h0, 1, 32'h55AA_55AA, 0));
        vecs.push_back(mk(1, 1, 32'h0000_0007, 32'h0000_BEEF, T_LH, 32'h0,
                          1, 4'b1000, 14'h0001, 32'hBEEF_BEEF, 1, 32'h0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_0001, 32'h0102_0304, T_LW, 32'h0,
                          1, 4'b1111, 14'h0000, 32'h0102_0304, 1, 32'h0, 0));
`endif

        // Reset held with both ports requesting: nothing is granted.
        a_if.req_valid = 1'b1; a_if.req_type = T_LW; a_if.req_addr = 32'h40;
        b_if.req_valid = 1'b1; b_if.req_type = T_LB; b_if.req_we = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("rst%0d_ready_a", c), 32'(a_if.req_ready), 32'd0);
            check($sformatf("rst%0d_ready_b", c), 32'(b_if.req_ready), 32'd0);
            check($sformatf("rst%0d_en", c), 32'(dmem_en), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_ports();
        #1;
        check("rst_rel_a_valid", 32'(a_if.rsp_valid), 32'd0);
        check("rst_rel_b_valid", 32'(b_if.rsp_valid), 32'd0);
        check("rst_rel_a_rdata", a_if.rsp_rdata, 32'h0);
        check("rst_rel_a_err", 32'(a_if.rsp_err), 32'd0);

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], i);

        // Starvation guard: A wins 8 cycles, then B is forced once, repeating.
        @(posedge clk);
        @(negedge clk);
        dmem_dout = 32'h0BAD_F00D;
        a_if.req_valid = 1'b1; a_if.req_we = 1'b0; a_if.req_addr = 32'h20; a_if.req_type = T_LW;
        b_if.req_valid = 1'b1; b_if.req_we = 1'b0; b_if.req_addr = 32'h41; b_if.req_type = T_LBU;
        prev_a = 1'b0;
        prev_b = 1'b0;
        for (int c = 0; c < 18; c++) begin
            #1;
            exp_b = (c == 8) || (c == 17);
            check($sformatf("stv%0d_ready_a", c), 32'(a_if.req_ready), 32'(!exp_b));
            check($sformatf("stv%0d_ready_b", c), 32'(b_if.req_ready), 32'(exp_b));
            check($sformatf("stv%0d_rsp_a", c), 32'(a_if.rsp_valid), 32'(prev_a));
            check($sformatf("stv%0d_rsp_b", c), 32'(b_if.rsp_valid), 32'(prev_b));
            if (prev_b) begin
                check($sformatf("stv%0d_b_type", c), 32'(b_if.rsp_type), 32'(T_LBU));
                check($sformatf("stv%0d_b_off", c), 32'(b_if.rsp_offset), 32'd1);
                check($sformatf("stv%0d_b_rdata", c), b_if.rsp_rdata, 32'h0BAD_F00D);
            end
            prev_a = !exp_b;
            prev_b = exp_b;
            @(negedge clk);
        end
        idle_ports();
        #1;
        check("stv_end_rsp_b", 32'(b_if.rsp_valid), 32'd1);
        check("stv_end_rsp_a", 32'(a_if.rsp_valid), 32'd0);

        // Reset arrives the cycle after an accepted A load: response is dropped.
        @(negedge clk);
        a_if.req_valid = 1'b1; a_if.req_we = 1'b0; a_if.req_addr = 32'h30; a_if.req_type = T_LW;
        #1;
        check("inflt_ready_a", 32'(a_if.req_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        dmem_dout = 32'h7777_7777;
        #1;
        check("inflt_rsp_a", 32'(a_if.rsp_valid), 32'd0);
        check("inflt_ready_rst", 32'(a_if.req_ready), 32'd0);
        check("inflt_en_rst", 32'(dmem_en), 32'd0);
        @(negedge clk);
        idle_ports();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("inflt_rel_rsp_a", 32'(a_if.rsp_valid), 32'd0);
        check("inflt_rel_rsp_b", 32'(b_if.rsp_valid), 32'd0);
        @(posedge clk);
        #2;
        check("inflt_post_rsp_a", 32'(a_if.rsp_valid), 32'd0);
        check("inflt_post_rsp_b", 32'(b_if.rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
